traffic_ctrl_gen: RTL and testbench

TRAFFIC_CTRL_GEN -- requirements
Module: traffic_ctrl_gen

---
 rtl/traffic_ctrl_gen.sv | 135 +++++++++++++
 tb/tb_traffic_ctrl_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_ctrl_gen.sv
// Highway/farm-road junction controller driven by a prescaled phase timer.
// Define TRAFFIC_CTRL_ALLRED_EN to insert the AR1/AR2 all-red clearance phases.
module traffic_ctrl_gen #(
  parameter int TW      = 8,
  parameter int PRESC   = 16,
  parameter int GMIN_HW = 25,
  parameter int FG_MAX  = 20,
  parameter int YEL_T   = 4,
  parameter int AR_T    = 2
) (
  input  logic       CK,
  input  logic       CLRN,
  input  logic       FM,
  input  logic       TEST,
  output logic       GRN1,
  output logic       YLW1,
  output logic       RED1,
  output logic       GRN2,
  output logic       YLW2,
  output logic       RED2,
  output logic [2:0] PHASE
);

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    FG  = 3'd3,
    FY  = 3'd4,
    AR2 = 3'd5
  } phase_t;

  // Reject parameter sets whose durations cannot be represented by the timer.
  if (TW < 1 || TW > 31) begin : g_bad_tw
    $error("traffic_ctrl_gen: TW out of range");
  end
  if (PRESC < 1 || PRESC > 65536) begin : g_bad_presc
    $error("traffic_ctrl_gen: PRESC out of range");
  end
  if (GMIN_HW < 1 || GMIN_HW > (2 ** TW) - 1) begin : g_bad_gmin
    $error("traffic_ctrl_gen: GMIN_HW out of range");
  end
  if (FG_MAX < 1 || FG_MAX > (2 ** TW) - 1) begin : g_bad_fgmax
    $error("traffic_ctrl_gen: FG_MAX out of range");
  end
  if (YEL_T < 1 || YEL_T > (2 ** TW) - 1) begin : g_bad_yel
    $error("traffic_ctrl_gen: YEL_T out of range");
  end
  if (AR_T < 1 || AR_T > (2 ** TW) - 1) begin : g_bad_ar
    $error("traffic_ctrl_gen: AR_T out of range");
  end

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PLAST  = PW'(PRESC - 1);
  localparam logic [TW-1:0] TMAX   = '1;
  localparam logic [TW-1:0] GMIN_V = TW'(GMIN_HW);
  localparam logic [TW-1:0] FGMX_V = TW'(FG_MAX);
  localparam logic [TW-1:0] YEL_V  = TW'(YEL_T);
`ifdef TRAFFIC_CTRL_ALLRED_EN
  localparam logic [TW-1:0] AR_V   = TW'(AR_T);
`endif

  phase_t          state;
  phase_t          nxt;
  logic [TW-1:0]   timer;
  logic [PW-1:0]   presc;
  logic            test_q;
  logic            freq;
  logic            tick;

  // Lamp pattern {GRN1,YLW1,RED1,GRN2,YLW2,RED2}; anything unexpected shows all-red.
  function automatic logic [5:0] lamps(input phase_t s);
    case (s)
      HG:      lamps = 6'b100_001;
      HY:      lamps = 6'b010_001;
      FG:      lamps = 6'b001_100;
      FY:      lamps = 6'b001_010;
      default: lamps = 6'b001_001;
    endcase
  endfunction

  assign tick  = TEST | (presc == PLAST);
  assign PHASE = state;

  // Next-phase selection from the current phase, elapsed ticks and the farm request.
  always_comb begin
    nxt = state;
    case (state)
      HG: if (freq && timer >= GMIN_V) nxt = HY;
`ifdef TRAFFIC_CTRL_ALLRED_EN
      HY:  if (timer >= YEL_V) nxt = AR1;
      AR1: if (timer >= AR_V)  nxt = FG;
      FY:  if (timer >= YEL_V) nxt = AR2;
      AR2: if (timer >= AR_V)  nxt = HG;
`else
      HY:  if (timer >= YEL_V) nxt = FG;
      FY:  if (timer >= YEL_V) nxt = HG;
      AR1: nxt = HG;
      AR2: nxt = HG;
`endif
      FG: if (timer >= FGMX_V || (!FM && timer != '0)) nxt = FY;
      default: nxt = AR2;
    endcase
  end

  // Phase register, timer, prescaler, request latch and registered lamps.
  always_ff @(posedge CK) begin
    if (!CLRN) begin
      state  <= HG;
      timer  <= '0;
      presc  <= '0;
      freq   <= 1'b0;
      test_q <= 1'b0;
      {GRN1, YLW1, RED1, GRN2, YLW2, RED2} <= lamps(HG);
    end else begin
      state  <= nxt;
      test_q <= TEST;
      {GRN1, YLW1, RED1, GRN2, YLW2, RED2} <= lamps(nxt);
      if (nxt != state)
        timer <= '0;
      else if (tick && timer != TMAX)
        timer <= timer + 1'b1;
      // Leaving test mode restarts the prescaler so the first slow tick is a full period.
      if ((test_q && !TEST) || presc == PLAST)
        presc <= '0;
      else
        presc <= presc + 1'b1;
      if (FM)
        freq <= 1'b1;
      else if (nxt == FG && state != FG)
        freq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_traffic_ctrl_gen.sv
// Bench for traffic_ctrl_gen: table-driven phase model checked every cycle plus
// hand-computed milestone cycles. Follows TRAFFIC_CTRL_ALLRED_EN like the RTL.
module tb_traffic_ctrl_gen;

  localparam int TW      = 8;
  localparam int PRESC   = 16;
  localparam int GMIN_HW = 25;
  localparam int FG_MAX  = 20;
  localparam int YEL_T   = 4;
  localparam int AR_T    = 2;
`ifdef TRAFFIC_CTRL_ALLRED_EN
  localparam bit ALLRED = 1'b1;
`else
  localparam bit ALLRED = 1'b0;
`endif

  logic       CK = 1'b0;
  logic       CLRN = 1'b0;
  logic       FM = 1'b0;
  logic       TEST = 1'b1;
  logic       GRN1, YLW1, RED1, GRN2, YLW2, RED2;
  logic [2:0] PHASE;

  traffic_ctrl_gen #(
    .TW(TW), .PRESC(PRESC), .GMIN_HW(GMIN_HW), .FG_MAX(FG_MAX),
    .YEL_T(YEL_T), .AR_T(AR_T)
  ) dut (
    .CK(CK), .CLRN(CLRN), .FM(FM), .TEST(TEST),
    .GRN1(GRN1), .YLW1(YLW1), .RED1(RED1),
    .GRN2(GRN2), .YLW2(YLW2), .RED2(RED2),
    .PHASE(PHASE)
  );

  always #5 CK = ~CK;

  int vecs = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit rec_en = 1'b0;
  int last_phase = 0;
  int ev_ph[$];
  int ev_cyc[$];
  int exp_ph[$];
  int exp_cyc[$];

  int m_phase = 0;
  int m_t = 0;
  int m_pre = 0;
  bit m_testq = 1'b0;
  bit m_req = 1'b0;

  // Phase that follows p once its duration has expired.
  function automatic int succ(input int p);
    case (p)
      0: succ = 1;
      1: succ = ALLRED ? 2 : 3;
      2: succ = 3;
      3: succ = 4;
      4: succ = ALLRED ? 5 : 0;
      default: succ = 0;
    endcase
  endfunction

  function automatic int limit(input int p);
    case (p)
      0: limit = GMIN_HW;
      1: limit = YEL_T;
      2: limit = AR_T;
      3: limit = FG_MAX;
      default: limit = (p == 4) ? YEL_T : AR_T;
    endcase
  endfunction

  // {GRN1,YLW1,RED1,GRN2,YLW2,RED2} each phase must show.
  function automatic int lampsOf(input int p);
    case (p)
      0: lampsOf = 'b100001;
      1: lampsOf = 'b010001;
      3: lampsOf = 'b001100;
      4: lampsOf = 'b001010;
      default: lampsOf = 'b001001;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int got, input int expv);
    vecs++;
    if (got != expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  task automatic applyStimulus(input bit clrn, input bit fm, input bit test);
    CLRN = clrn;
    FM   = fm;
    TEST = test;
  endtask

  // One reset edge; returns at the negedge of cycle 0 with CLRN released.
  task automatic doReset(input bit fm, input bit test);
    @(negedge CK);
    applyStimulus(1'b0, fm, test);
    @(negedge CK);
    chk_en = 1'b1;
    applyStimulus(1'b1, fm, test);
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge CK);
  endtask

  task automatic waitPhase(input int p, input int budget, input string name);
    int k;
    k = 0;
    while (int'(PHASE) != p && k < budget) begin
      @(negedge CK);
      k++;
    end
    checkOutput(name, int'(PHASE), p);
  endtask

  // Behavioural model: elapsed ticks in the current phase against a duration table.
  always @(posedge CK) begin
    if (!CLRN) begin
      m_phase = 0;
      m_t     = 0;
      m_pre   = 0;
      m_req   = 1'b0;
      m_testq = 1'b0;
      cyc     = 0;
    end else begin
      bit tk;
      int np;
      tk = TEST || (m_pre == PRESC - 1);
      np = m_phase;
      if (m_phase > 5)
        np = 5;
      else if (!ALLRED && (m_phase == 2 || m_phase == 5))
        np = 0;
      else if (m_t >= limit(m_phase) && (m_phase != 0 || m_req))
        np = succ(m_phase);
      else if (m_phase == 3 && !FM && m_t >= 1)
        np = 4;
      if (np == 3 && m_phase != 3) m_req = 1'b0;
      if (FM) m_req = 1'b1;
      if (np != m_phase) m_t = 0;
      else if (tk && m_t < (2 ** TW) - 1) m_t = m_t + 1;
      if ((m_testq && !TEST) || m_pre == PRESC - 1) m_pre = 0;
      else m_pre = m_pre + 1;
      m_testq = TEST;
      m_phase = np;
      cyc++;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge CK) begin
    if (chk_en) begin
      checkOutput("phase", int'(PHASE), m_phase);
      checkOutput("lamps", int'({GRN1, YLW1, RED1, GRN2, YLW2, RED2}), lampsOf(m_phase));
    end
  end

  // Records each phase change with the cycle in which it first appears.
  always @(negedge CK) begin
    if (chk_en && rec_en) begin
      if (int'(PHASE) != last_phase) begin
        ev_ph.push_back(int'(PHASE));
        ev_cyc.push_back(cyc);
      end
      last_phase = int'(PHASE);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    if (ALLRED) begin
      exp_ph  = '{1, 2, 3, 4, 5, 0};
      exp_cyc = '{26, 31, 34, 55, 60, 63};
    end else begin
      exp_ph  = '{1, 3, 4, 0};
      exp_cyc = '{26, 31, 52, 57};
    end

    // Reset state, then no farm traffic: highway green held.
    doReset(1'b0, 1'b1);
    checkOutput("rst_phase", int'(PHASE), 0);
    checkOutput("rst_lamps", int'({GRN1, YLW1, RED1, GRN2, YLW2, RED2}), 'b100001);
    for (int i = 0; i < 200; i++) begin
      @(negedge CK);
      checkOutput("hold_hg", int'({PHASE, GRN1, RED2}), 'b000_11);
    end

    // Continuous farm demand: full cycle milestones.
    doReset(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    ev_ph.delete();
    ev_cyc.delete();
    last_phase = 0;
    rec_en = 1'b1;
    runCycles(70);
    rec_en = 1'b0;
    checkOutput("event_count", ev_ph.size(), exp_ph.size());
    for (int i = 0; i < exp_ph.size() && i < ev_ph.size(); i++) begin
      checkOutput("event_phase", ev_ph[i], exp_ph[i]);
      checkOutput("event_cycle", ev_cyc[i], exp_cyc[i]);
    end

    // Farm vehicle leaves during FG: early end of farm green.
    doReset(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    runCycles(40);
    checkOutput("fg_at_40", int'(PHASE), 3);
    applyStimulus(1'b1, 1'b0, 1'b1);
    runCycles(1);
    checkOutput("fy_at_41", int'(PHASE), 4);

    // Reset pulse in FY with FM high during reset: request must not survive.
    doReset(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitPhase(4, 80, "reach_fy");
    applyStimulus(1'b0, 1'b1, 1'b1);
    @(negedge CK);
    checkOutput("fy_rst_phase", int'(PHASE), 0);
    checkOutput("fy_rst_lamps", int'({GRN1, YLW1, RED1, GRN2, YLW2, RED2}), 'b100001);
    applyStimulus(1'b1, 1'b0, 1'b1);
    runCycles(30);
    checkOutput("freq_cleared", int'(PHASE), 0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    runCycles(5);

    // Normal-mode prescaler: highway yellow within 26 tick periods.
    doReset(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitPhase(1, 430, "reach_hy_presc");
    checkOutput("hy_presc_bound", int'(cyc <= 416 && cyc >= 385), 1);

    // Leaving test mode mid-phase restarts the prescaler (HY at cycle 357).
    doReset(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    runCycles(3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitPhase(1, 400, "reach_hy_switch");
    checkOutput("hy_switch_cycle", cyc, 357);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
